// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - SPI pin and program-burst signal bundle for prog_loader
interface prog_loader_if;
    logic       spi_sck;
    logic       spi_cs_n;
    logic       spi_mosi;
    logic       prog_enable;
    logic [7:0] prog_data;
    logic       busy;
    logic       done;
    logic [1:0] error;

    modport master (
        output spi_sck, spi_cs_n, spi_mosi,
        input  prog_enable, prog_data, busy, done, error
    );

    modport slave (
        input  spi_sck, spi_cs_n, spi_mosi,
        output prog_enable, prog_data, busy, done, error
    );
endinterface

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - SPI-slave program loader: buffers, validates and bursts an image
module prog_loader #(
    parameter int MAX_BYTES   = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clock,
    input  logic         rst_n,
    prog_loader_if.slave bus
);
    localparam int IW = $clog2(MAX_BYTES + 1);
    localparam int AW = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam logic [IW-1:0] IDX_ONE = 1;
    localparam logic [7:0]    MAX_N   = 8'(MAX_BYTES);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN, S_DATA, S_CSUM, S_WAIT_END, S_STREAM, S_ERROR
    } state_t;

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic       sck_prev_q, sck_prev_d;
    logic       cs_prev_q, cs_prev_d;
    logic [6:0] shift_q, shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       byte_vld_q, byte_vld_d;
    logic [7:0] byte_q, byte_d;
    state_t     state_q, state_d;
    logic [IW-1:0] len_q, len_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [7:0] sum_q, sum_d;
    logic       prog_enable_q, prog_enable_d;
    logic [7:0] prog_data_q, prog_data_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [1:0] error_q, error_d;

    logic [7:0]    mem_q [0:(1<<AW)-1];
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [7:0]    mem_wdata;

    logic          sck_s, cs_s, mosi_s;
    logic          cs_fall, cs_rise;
    logic [IW-1:0] idx_inc;
    logic [7:0]    csum_total;

    assign sck_s      = sck_sync_q[SYNC_STAGES-1];
    assign cs_s       = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync_q[SYNC_STAGES-1];
    assign cs_fall    = cs_prev_q & ~cs_s;
    assign cs_rise    = ~cs_prev_q & cs_s;
    assign idx_inc    = idx_q + IDX_ONE;
    assign csum_total = sum_q + byte_q;

    // Next-state logic: pin synchronizers, byte assembly and the frame/burst FSM
    always_comb begin
        sck_sync_d    = {sck_sync_q[SYNC_STAGES-2:0], bus.spi_sck};
        cs_sync_d     = {cs_sync_q[SYNC_STAGES-2:0], bus.spi_cs_n};
        mosi_sync_d   = {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
        sck_prev_d    = sck_s;
        cs_prev_d     = cs_s;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        byte_vld_d    = 1'b0;
        byte_d        = byte_q;
        state_d       = state_q;
        len_d         = len_q;
        idx_d         = idx_q;
        sum_d         = sum_q;
        prog_enable_d = 1'b0;
        prog_data_d   = 8'h00;
        done_d        = done_q;
        error_d       = error_q;
        mem_we        = 1'b0;
        mem_waddr     = idx_q[AW-1:0];
        mem_wdata     = byte_q;

        // Deselect discards any partial byte
        if (cs_s) begin
            bit_cnt_d = 3'd0;
        end else if (sck_s && !sck_prev_q) begin
            shift_d   = {shift_q[5:0], mosi_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                byte_vld_d = 1'b1;
                byte_d     = {shift_q, mosi_s};
            end
        end

        case (state_q)
            S_IDLE: begin
                if (cs_fall) begin
                    done_d  = 1'b0;
                    error_d = 2'd0;
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (byte_vld_q) begin
                    if (byte_q == 8'h00 || byte_q > MAX_N) begin
                        error_d = 2'd1;
                        state_d = S_ERROR;
                    end else begin
                        len_d   = byte_q[IW-1:0];
                        sum_d   = byte_q;
                        idx_d   = '0;
                        state_d = S_DATA;
                    end
                end else if (cs_rise) begin
                    error_d = 2'd3;
                    state_d = S_ERROR;
                end
            end
            S_DATA: begin
                if (byte_vld_q) begin
                    mem_we  = 1'b1;
                    sum_d   = csum_total;
                    idx_d   = idx_inc;
                    if (idx_inc == len_q) state_d = S_CSUM;
                end else if (cs_rise) begin
                    error_d = 2'd3;
                    state_d = S_ERROR;
                end
            end
            S_CSUM: begin
                if (byte_vld_q) begin
                    if (csum_total == 8'h00) begin
                        state_d = S_WAIT_END;
                    end else begin
                        error_d = 2'd2;
                        state_d = S_ERROR;
                    end
                end else if (cs_rise) begin
                    error_d = 2'd3;
                    state_d = S_ERROR;
                end
            end
            S_WAIT_END: begin
                if (byte_vld_q) begin
                    error_d = 2'd3;
                    state_d = S_ERROR;
                end else if (cs_s) begin
                    // First beat goes out on this edge so the burst is gap-free
                    prog_enable_d = 1'b1;
                    prog_data_d   = mem_q[0];
                    idx_d         = IDX_ONE;
                    state_d       = S_STREAM;
                end
            end
            S_STREAM: begin
                if (idx_q == len_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    prog_enable_d = 1'b1;
                    prog_data_d   = mem_q[idx_q[AW-1:0]];
                    idx_d         = idx_inc;
                end
            end
            S_ERROR: begin
                if (cs_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CSUM) ||
                 (state_d == S_WAIT_END) || (state_d == S_STREAM);
    end

    // State and registered outputs; async reset drops the burst immediately
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync_q    <= '0;
            cs_sync_q     <= '1;
            mosi_sync_q   <= '0;
            sck_prev_q    <= 1'b0;
            cs_prev_q     <= 1'b1;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            byte_vld_q    <= 1'b0;
            byte_q        <= '0;
            state_q       <= S_IDLE;
            len_q         <= '0;
            idx_q         <= '0;
            sum_q         <= '0;
            prog_enable_q <= 1'b0;
            prog_data_q   <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 2'd0;
        end else begin
            sck_sync_q    <= sck_sync_d;
            cs_sync_q     <= cs_sync_d;
            mosi_sync_q   <= mosi_sync_d;
            sck_prev_q    <= sck_prev_d;
            cs_prev_q     <= cs_prev_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            byte_vld_q    <= byte_vld_d;
            byte_q        <= byte_d;
            state_q       <= state_d;
            len_q         <= len_d;
            idx_q         <= idx_d;
            sum_q         <= sum_d;
            prog_enable_q <= prog_enable_d;
            prog_data_q   <= prog_data_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            error_q       <= error_d;
        end
    end

    // Image buffer; contents survive between frames, only 0..N-1 are replayed
    always_ff @(posedge clock) begin
        if (mem_we) mem_q[mem_waddr] <= mem_wdata;
    end

    assign bus.prog_enable = prog_enable_q;
    assign bus.prog_data   = prog_data_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.error       = error_q;
endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed scoreboard bench for prog_loader
module tb_prog_loader;
    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    prog_loader_if bus ();

    prog_loader #(.MAX_BYTES(64), .SYNC_STAGES(2)) dut (
        .clock (clock),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int         n_assert = 0;
    int         n_fail   = 0;
    int         beats    = 0;
    int         bursts   = 0;
    logic       prev_en  = 1'b0;
    logic [7:0] sb [$];
    logic [7:0] tx [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Burst monitor: pops the scoreboard on each beat and checks idle outputs
    always @(negedge clock) begin
        if (rst_n) begin
            if (bus.prog_enable) begin
                beats++;
                if (!prev_en) bursts++;
                chk("busy_in_burst", 32'(bus.busy), 32'd1);
                if (sb.size() == 0) chk("beat_expected", 32'd0, 32'd1);
                else                chk("prog_data", 32'(bus.prog_data), 32'(sb.pop_front()));
            end else begin
                chk("idle_data_zero", 32'(bus.prog_data), 32'd0);
            end
            chk("done_err_excl", 32'(bus.done && (bus.error != 2'd0)), 32'd0);
            prev_en = bus.prog_enable;
        end else begin
            prev_en = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            bus.spi_mosi = b[i];
            repeat (4) @(negedge clock);
            bus.spi_sck = 1'b1;
            repeat (4) @(negedge clock);
            bus.spi_sck = 1'b0;
        end
    endtask

    task automatic send_tx();
        beats  = 0;
        bursts = 0;
        bus.spi_cs_n = 1'b0;
        repeat (4) @(negedge clock);
        foreach (tx[i]) send_byte(tx[i]);
        repeat (4) @(negedge clock);
        bus.spi_cs_n = 1'b1;
    endtask

    task automatic build(input int n, input logic [7:0] first, input logic [7:0] step,
                         input logic [7:0] cadj, input bit good);
        logic [7:0] s;
        logic [7:0] d;
        logic [7:0] c;
        tx.delete();
        s = 8'(n);
        d = first;
        tx.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            tx.push_back(d);
            if (good) sb.push_back(d);
            s = s + d;
            d = d + step;
        end
        c = 8'h00 - s;
        tx.push_back(c + cadj);
    endtask

    task automatic expect_end(input string tag, input int eb, input int ebu,
                              input logic ed, input logic [1:0] ee);
        chk({tag, "_beats"},  32'(beats),       32'(eb));
        chk({tag, "_bursts"}, 32'(bursts),      32'(ebu));
        chk({tag, "_done"},   32'(bus.done),    32'(ed));
        chk({tag, "_error"},  32'(bus.error),   32'(ee));
        chk({tag, "_busy"},   32'(bus.busy),    32'd0);
        chk({tag, "_sb"},     32'(sb.size()),   32'd0);
    endtask

    initial begin
        int seen;
        bus.spi_sck  = 1'b0;
        bus.spi_cs_n = 1'b1;
        bus.spi_mosi = 1'b0;
        repeat (3) @(negedge clock);
        chk("rst_prog_enable", 32'(bus.prog_enable), 32'd0);
        chk("rst_prog_data",   32'(bus.prog_data),   32'd0);
        chk("rst_busy",        32'(bus.busy),        32'd0);
        chk("rst_done",        32'(bus.done),        32'd0);
        chk("rst_error",       32'(bus.error),       32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clock);

        build(3, 8'h11, 8'h11, 8'h00, 1'b1);
        chk("valid_csum_byte", 32'(tx[4]), 32'h97);
        send_tx();
        repeat (30) @(negedge clock);
        expect_end("valid", 3, 1, 1'b1, 2'd0);

        build(3, 8'h11, 8'h11, 8'h01, 1'b0);
        send_tx();
        repeat (30) @(negedge clock);
        expect_end("csum_bad", 0, 0, 1'b0, 2'd2);

        tx = '{8'h00, 8'h00};
        send_tx();
        repeat (30) @(negedge clock);
        expect_end("len_zero", 0, 0, 1'b0, 2'd1);

        tx = '{8'd65};
        send_tx();
        repeat (30) @(negedge clock);
        expect_end("len_65", 0, 0, 1'b0, 2'd1);

        build(3, 8'h11, 8'h11, 8'h00, 1'b0);
        void'(tx.pop_back());
        void'(tx.pop_back());
        send_tx();
        repeat (30) @(negedge clock);
        expect_end("abort", 0, 0, 1'b0, 2'd3);

        build(3, 8'hA0, 8'h05, 8'h00, 1'b1);
        send_tx();
        repeat (30) @(negedge clock);
        expect_end("recover", 3, 1, 1'b1, 2'd0);

        build(3, 8'h11, 8'h11, 8'h00, 1'b0);
        tx.push_back(8'h55);
        send_tx();
        repeat (30) @(negedge clock);
        expect_end("trailing", 0, 0, 1'b0, 2'd3);

        build(64, 8'h00, 8'h01, 8'h00, 1'b1);
        send_tx();
        repeat (100) @(negedge clock);
        expect_end("full64", 64, 1, 1'b1, 2'd0);

        build(64, 8'h40, 8'h03, 8'h00, 1'b1);
        send_tx();
        seen = 0;
        for (int c = 0; c < 200 && seen < 10; c++) begin
            @(negedge clock);
            if (bus.prog_enable) seen++;
        end
        chk("reached_beat10", 32'(seen), 32'd10);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_prog_enable", 32'(bus.prog_enable), 32'd0);
        chk("arst_busy",        32'(bus.busy),        32'd0);
        chk("arst_done",        32'(bus.done),        32'd0);
        sb.delete();
        repeat (3) @(negedge clock);
        rst_n = 1'b1;
        repeat (3) @(negedge clock);
        chk("post_rst_busy",  32'(bus.busy),  32'd0);
        chk("post_rst_error", 32'(bus.error), 32'd0);

        build(5, 8'h3C, 8'h11, 8'h00, 1'b1);
        send_tx();
        repeat (30) @(negedge clock);
        expect_end("after_rst", 5, 1, 1'b1, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/prog_loader.md
# prog_loader

SPI-slave program loader that fills the FSM controller's instruction memory. It receives a length-prefixed, checksummed program image from an off-chip host over a 3-wire SPI link (mode 0). It buffers the image and validates it, then replays it to the controller's `prog_enable`/`data_in` port as one contiguous burst of one byte per clock. It sits between the chip's input pins and the controller; during a burst its outputs are muxed onto the controller's `data_in`.

## Interface
- `MAX_BYTES`, 64: capacity of the internal image buffer in bytes. Legal range is 1..255.
- `SYNC_STAGES`, 2: flop depth of each pin synchronizer. Minimum 2.

- `clock` input, 1 bit: single system clock. All logic is in this domain.
- `rst_n` input, 1 bit: reset, asynchronous, active-low.
- `spi_sck` input, 1 bit: host serial clock. Asynchronous to `clock`. Its frequency must be ≤ clock/4.
- `spi_cs_n` input, 1 bit: frame select, active-low. Asynchronous.
- `spi_mosi` input, 1 bit: serial data, MSB first. Sampled on `spi_sck` rising edges.
- `prog_enable` output, 1 bit: high on each burst beat. Drives the controller's `prog_enable`.
- `prog_data` output, 8 bits: burst byte. It is 0 whenever `prog_enable` is 0.
- `busy` output, 1 bit: a frame is in progress or a burst is in progress.
- `done` output, 1 bit: sticky flag. The last frame loaded successfully.
- `error` output, 2 bits: sticky code. 0 means none, 1 means bad length, 2 means checksum mismatch, 3 means framing error.

## Operation
- **Frame format** (all bytes MSB first):
  - length byte N;
  - N data bytes;
  - checksum byte C.
  - The frame is valid when (N + sum of data bytes + C) mod 256 == 0.
- **Synchronization and byte assembly:**
  - `spi_sck`, `spi_cs_n` and `spi_mosi` each pass through `SYNC_STAGES` flops.
  - A rising edge of the synchronized sck while synchronized cs_n is low shifts synchronized mosi into an 8-bit shift register.
  - The 8th bit produces a one-cycle internal byte strobe.
  - Synchronized cs_n high clears the bit counter. A partial byte is discarded.
- **Frame start:** a synchronized cs_n high→low transition seen in IDLE. Transitions in any other state are ignored.
- **States:**
  - **IDLE:** `busy`=0. On frame start, clear `done` and `error` and go to LEN.
  - **LEN:**
    - On a byte: if N==0 or N>`MAX_BYTES`, set `error`=1 and go to ERROR.
    - Otherwise latch N, set sum=N, index=0, and go to DATA.
  - **DATA:** on a byte, write buf[index], add the byte to sum, increment index. When index==N, go to CSUM.
  - **CSUM:** on a byte, if (sum+C) mod 256 == 0, go to WAIT_END. Otherwise set `error`=2 and go to ERROR.
  - **WAIT_END:**
    - A further byte sets `error`=3 and goes to ERROR.
    - Synchronized cs_n high goes to STREAM with index=0.
  - **STREAM:**
    - Drive `prog_enable`=1 and `prog_data`=buf[index] for exactly N consecutive cycles, with index = 0..N-1.
    - All SPI activity is ignored during STREAM.
    - After the last beat, set `done`=1 and go to IDLE.
  - **ERROR:** `busy`=0. Go to IDLE when synchronized cs_n is high. `error` holds its code until the next frame start.
  - **Framing abort:** synchronized cs_n rising in LEN, DATA or CSUM sets `error`=3 and goes to ERROR.
- `busy` = 1 in LEN, DATA, CSUM, WAIT_END and STREAM.
- The buffer is not cleared between frames. Only bytes 0..N-1 are ever replayed.
- Arithmetic:
  - sum is 8 bits, modulo 256.
  - index is ⌈log2(MAX_BYTES+1)⌉ bits.
  - N is compared unsigned.

## Timing
- **Reset values:** `prog_enable`=0, `prog_data`=0, `busy`=0, `done`=0, `error`=0, state=IDLE, synchronizers at idle level (sck=0, cs_n=1).
- Reset asserted mid-burst drops `prog_enable` to 0 immediately (asynchronously). The controller then holds a partial program, and the host must reload.
- `prog_enable` and `prog_data` are registered, with no combinational path from the inputs.
- The byte strobe occurs `SYNC_STAGES`+1 clocks after the 8th `spi_sck` rising edge reaches the pin.
- The first burst beat is on the clock edge following the cycle in which WAIT_END sees synchronized cs_n high.
- The burst is gap-free: exactly N cycles with `prog_enable`=1.
- On the cycle after the last beat: `prog_enable`=0, `prog_data`=0, `busy`=0, `done`=1, all together.
- `error` and `done` update on the same edge as the corresponding state transition. Both are never 1 simultaneously.

## Test plan
- **Valid frame:** N=3, data 0x11,0x22,0x33, C=0x97, then cs_n high → `prog_enable` high for exactly 3 consecutive cycles with `prog_data` 0x11,0x22,0x33. Afterwards `done`=1, `error`=0, `busy`=0.
- **Checksum mismatch:** same frame with C=0x98 → `error`=2, `prog_enable` never asserts, `done`=0.
- **Bad length:** N=0 → `error`=1. N=65 with `MAX_BYTES`=64 → `error`=1. Neither produces a burst.
- **Framing abort then recovery:** cs_n raised after 2 of 3 data bytes → `error`=3. A following valid frame clears `error` and sets `done`=1 after a 3-beat burst.
- **Trailing byte and full buffer:** an extra byte after C → `error`=3. N=64 with bytes 0x00..0x3F → exactly 64 contiguous beats in order, `done`=1.
- **Async reset mid-burst:** assert `rst_n`=0 at beat 10 of a 64-byte burst → `prog_enable`, `busy` and `done` read 0 before the next clock edge. After release, the block is in IDLE and accepts a new frame.
